// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: pauses the CPU and hands the work-RAM port to the hiscore engine.
// Ports: clk_sys/reset (async, active-high); hs_* engine side (intents, address, write data/strobe,
// read data/valid, busy, abort); pause_req/cpu_paused to the pause module; cpu_* core side;
// ram_* shared RAM port; vblank (IDLE->REQ gating only when HSARB_VBLANK_SYNC_EN is defined).
module hiscore_ram_arbiter #(
  parameter int AW      = 11,
  parameter int RD_LAT  = 1,
  parameter int SETTLE  = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write_enable,
  output logic [7:0]    hs_data_out,
  output logic          hs_rdata_valid,
  output logic          hs_busy,
  output logic          hs_abort,
  output logic          pause_req,
  input  logic          cpu_paused,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  input  logic          vblank
);
  localparam int CMAX = (TIMEOUT > SETTLE) ? ((TIMEOUT > HOLD) ? TIMEOUT : HOLD)
                                           : ((SETTLE > HOLD) ? SETTLE : HOLD);
  localparam int CW = $clog2(CMAX + 1);
  localparam int VMAX = RD_LAT + 1;
  localparam int RW = $clog2(VMAX + 1);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETTLE, S_GRANT, S_RELEASE} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic [AW-1:0] addr_q;
  logic intent, go, abort, rd;
  assign intent = hs_read_intent | hs_write_intent;
`ifdef HSARB_VBLANK_SYNC_EN
  assign go = intent & vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign go = intent;
`endif
  always_comb begin
    nxt = st;
    abort = 1'b0;
    case (st)
      S_IDLE:    nxt = go ? S_REQ : S_IDLE;
      S_REQ: begin
        if (!intent) nxt = S_IDLE;
        else if (cpu_paused) nxt = S_SETTLE;
        else if (cnt == CW'(TIMEOUT)) begin
          abort = 1'b1;
          nxt = S_IDLE;
        end
      end
      // SETTLE state spans SETTLE-1 cycles so grant lands SETTLE cycles after cpu_paused rose
      S_SETTLE: begin
        if (!intent) nxt = S_IDLE;
        else if (!cpu_paused) nxt = S_REQ;
        else if (int'(cnt) + 2 >= SETTLE) nxt = S_GRANT;
      end
      S_GRANT: begin
        if (!cpu_paused) begin
          abort = 1'b1;
          nxt = S_IDLE;
        end else if (!intent) nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (intent) nxt = S_GRANT;
        else if (int'(cnt) + 1 >= HOLD) nxt = S_IDLE;
      end
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st <= S_IDLE;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st) ? '0 : cnt + {{(CW-1){1'b0}}, ~&cnt};
    end
  end
  // busy drops combinationally the moment the CPU un-pauses so the engine never writes a running game
  assign hs_busy   = (st == S_GRANT) & cpu_paused;
  assign hs_abort  = abort;
  assign pause_req = (st != S_IDLE) & ~abort;
  assign ram_addr  = hs_busy ? hs_address : cpu_addr;
  assign ram_din   = hs_busy ? hs_data_in : cpu_din;
  assign ram_we    = hs_busy ? hs_write_enable : cpu_we & ~abort;
  assign cpu_dout  = ram_dout;
  // rcnt counts consecutive granted read cycles on an unchanged address; a write resets it
  assign rd = hs_busy & hs_read_intent & ~hs_write_enable;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      addr_q <= '0;
      hs_data_out <= '0;
    end else begin
      addr_q <= hs_address;
      hs_data_out <= ram_dout;
      rcnt <= !rd ? '0 : (hs_address != addr_q) ? RW'(1) : (rcnt == RW'(VMAX)) ? rcnt : rcnt + 1'b1;
    end
  end
  assign hs_rdata_valid = int'(rcnt) >= VMAX;
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: directed vector tables plus handshake sequences against a 1-cycle RAM model.
module tb_hiscore_ram_arbiter;
  logic clk_sys = 1'b0;
  logic reset;
  logic hs_read_intent, hs_write_intent, hs_write_enable;
  logic [10:0] hs_address, cpu_addr, ram_addr;
  logic [7:0] hs_data_in, hs_data_out, cpu_din, cpu_dout, ram_din, ram_dout;
  logic hs_rdata_valid, hs_busy, hs_abort, pause_req, cpu_paused, cpu_we, ram_we, vblank;
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [0:2047];
  logic mem_init = 1'b0;

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_arbiter #(.AW(11), .RD_LAT(1), .SETTLE(4), .HOLD(2), .TIMEOUT(100)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .hs_read_intent(hs_read_intent), .hs_write_intent(hs_write_intent),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write_enable(hs_write_enable),
    .hs_data_out(hs_data_out), .hs_rdata_valid(hs_rdata_valid), .hs_busy(hs_busy),
    .hs_abort(hs_abort), .pause_req(pause_req), .cpu_paused(cpu_paused),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .vblank(vblank)
  );

  always @(posedge clk_sys) begin
    if (!mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      mem[11'h123] <= 8'hA5;
      mem[11'h124] <= 8'h5A;
      ram_dout <= 8'h00;
      mem_init <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [10:0] ha; logic [7:0] hd; logic hw;
    logic [10:0] ca; logic [7:0] cd; logic cw;
    logic [10:0] ea; logic [7:0] ed; logic ew;
  } vec_t;
  vec_t idle_v[4];
  vec_t grant_v[4];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    hs_address = v.ha; hs_data_in = v.hd; hs_write_enable = v.hw;
    cpu_addr = v.ca; cpu_din = v.cd; cpu_we = v.cw;
    #1;
    chk({tag, "_addr"}, 32'(ram_addr), 32'(v.ea));
    chk({tag, "_din"}, 32'(ram_din), 32'(v.ed));
    chk({tag, "_we"}, 32'(ram_we), 32'(v.ew));
    chk({tag, "_cpu_dout"}, 32'(cpu_dout), 32'(ram_dout));
  endtask

  task automatic go_grant();
    hs_read_intent = 1'b1;
    for (int k = 0; k < 30 && !hs_busy; k++) tick();
    chk("grant_reached", 32'(hs_busy), 32'd1);
  endtask

  initial begin
    int ab, bz, pr;
    idle_v[0]  = '{11'h7FF, 8'hEE, 1'b1, 11'h010, 8'h55, 1'b0, 11'h010, 8'h55, 1'b0};
    idle_v[1]  = '{11'h123, 8'h01, 1'b0, 11'h011, 8'hC3, 1'b1, 11'h011, 8'hC3, 1'b1};
    idle_v[2]  = '{11'h000, 8'h77, 1'b1, 11'h012, 8'h0F, 1'b1, 11'h012, 8'h0F, 1'b1};
    idle_v[3]  = '{11'h3FF, 8'h00, 1'b0, 11'h7F0, 8'hF0, 1'b0, 11'h7F0, 8'hF0, 1'b0};
    grant_v[0] = '{11'h201, 8'h3C, 1'b1, 11'h0AA, 8'h99, 1'b1, 11'h201, 8'h3C, 1'b1};
    grant_v[1] = '{11'h202, 8'h4D, 1'b0, 11'h0AB, 8'h98, 1'b1, 11'h202, 8'h4D, 1'b0};
    grant_v[2] = '{11'h7FE, 8'h12, 1'b0, 11'h0AC, 8'h97, 1'b0, 11'h7FE, 8'h12, 1'b0};
    grant_v[3] = '{11'h203, 8'hE1, 1'b1, 11'h0AD, 8'h96, 1'b0, 11'h203, 8'hE1, 1'b1};
    reset = 1'b1; vblank = 1'b1;
    hs_read_intent = 1'b0; hs_write_intent = 1'b0; hs_write_enable = 1'b0;
    hs_address = 11'h123; hs_data_in = 8'h00;
    cpu_addr = 11'h055; cpu_din = 8'h00; cpu_we = 1'b0; cpu_paused = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_pause_req", 32'(pause_req), 32'd0);
    chk("rst_busy", 32'(hs_busy), 32'd0);
    chk("rst_abort", 32'(hs_abort), 32'd0);
    chk("rst_valid", 32'(hs_rdata_valid), 32'd0);
    chk("rst_data_out", 32'(hs_data_out), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h055);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(idle_v[i], $sformatf("idle%0d", i));
      tick();
    end
    hs_write_enable = 1'b0; cpu_we = 1'b0;
    tick();
    chk("idle_hs_we_dropped", 32'(mem[11'h000]), 32'h00);
    hs_address = 11'h123; cpu_addr = 11'h050;
    hs_read_intent = 1'b1;
    tick();
    chk("req_pause_req", 32'(pause_req), 32'd1);
    repeat (5) tick();
    chk("req_no_busy", 32'(hs_busy), 32'd0);
    cpu_paused = 1'b1;
    repeat (3) tick();
    chk("settle_no_busy", 32'(hs_busy), 32'd0);
    tick();
    chk("grant_busy", 32'(hs_busy), 32'd1);
    chk("grant_ram_addr", 32'(ram_addr), 32'h123);
    cpu_we = 1'b1; cpu_din = 8'hFF; cpu_addr = 11'h123;
    #1;
    chk("grant_cpu_we_blocked", 32'(ram_we), 32'd0);
    tick();
    chk("rd_valid_early", 32'(hs_rdata_valid), 32'd0);
    cpu_we = 1'b0;
    tick();
    chk("rd_valid", 32'(hs_rdata_valid), 32'd1);
    chk("rd_data", 32'(hs_data_out), 32'hA5);
    hs_address = 11'h124;
    tick();
    chk("rd_addr_change_clr", 32'(hs_rdata_valid), 32'd0);
    tick();
    chk("rd_valid2", 32'(hs_rdata_valid), 32'd1);
    chk("rd_data2", 32'(hs_data_out), 32'h5A);
    hs_write_enable = 1'b1;
    tick();
    chk("rd_write_clr", 32'(hs_rdata_valid), 32'd0);
    hs_write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(grant_v[i], $sformatf("grant%0d", i));
      tick();
    end
    hs_write_enable = 1'b0; cpu_we = 1'b0; cpu_addr = 11'h3AB;
    tick();
    chk("grant_wr_mem", 32'(mem[11'h201]), 32'h3C);
    chk("grant_cpu_ignored", 32'(mem[11'h0AA]), 32'h00);
    hs_read_intent = 1'b0; hs_write_intent = 1'b1;
    hs_address = 11'h000; hs_data_in = 8'h11; hs_write_enable = 1'b1;
    #1;
    chk("wr_same_cycle", 32'(ram_we), 32'd1);
    tick();
    hs_address = 11'h001; hs_data_in = 8'h22;
    tick();
    hs_write_enable = 1'b0;
    tick();
    chk("wr_byte0", 32'(mem[11'h000]), 32'h11);
    chk("wr_byte1", 32'(mem[11'h001]), 32'h22);
    hs_write_intent = 1'b0;
    tick();
    chk("rel_busy_low", 32'(hs_busy), 32'd0);
    chk("rel_pause_hold1", 32'(pause_req), 32'd1);
    tick();
    chk("rel_pause_hold2", 32'(pause_req), 32'd1);
    tick();
    chk("rel_pause_low", 32'(pause_req), 32'd0);
    chk("rel_port_cpu", 32'(ram_addr), 32'h3AB);
    cpu_paused = 1'b0;
    tick();
    hs_read_intent = 1'b1;
    tick();
    chk("drop_req_pause", 32'(pause_req), 32'd1);
    hs_read_intent = 1'b0;
    #1;
    chk("drop_no_abort", 32'(hs_abort), 32'd0);
    tick();
    chk("drop_pause_low", 32'(pause_req), 32'd0);
    hs_write_intent = 1'b1;
    ab = 0; bz = 0;
    repeat (100) begin
      tick();
      ab += int'(hs_abort);
      bz += int'(hs_busy);
    end
    chk("to_no_early_abort", 32'(ab), 32'd0);
    tick();
    bz += int'(hs_busy);
    chk("to_abort", 32'(hs_abort), 32'd1);
    chk("to_pause_low", 32'(pause_req), 32'd0);
    hs_write_intent = 1'b0;
    tick();
    chk("to_abort_pulse", 32'(hs_abort), 32'd0);
    chk("to_never_busy", 32'(bz), 32'd0);
    cpu_paused = 1'b1;
    hs_address = 11'h123;
    go_grant();
    hs_read_intent = 1'b0;
    tick();
    chk("regrant_rel_busy", 32'(hs_busy), 32'd0);
    chk("regrant_rel_pause", 32'(pause_req), 32'd1);
    hs_read_intent = 1'b1;
    tick();
    chk("regrant_busy", 32'(hs_busy), 32'd1);
    chk("regrant_pause", 32'(pause_req), 32'd1);
    hs_write_enable = 1'b1; cpu_we = 1'b1; cpu_paused = 1'b0;
    #1;
    chk("gabort_pulse", 32'(hs_abort), 32'd1);
    chk("gabort_busy", 32'(hs_busy), 32'd0);
    chk("gabort_we", 32'(ram_we), 32'd0);
    tick();
    chk("gabort_pulse_end", 32'(hs_abort), 32'd0);
    hs_write_enable = 1'b0; cpu_we = 1'b0; hs_read_intent = 1'b0;
    tick();
    cpu_paused = 1'b1;
    go_grant();
    chk("rst_pre_addr", 32'(ram_addr), 32'h123);
    #2 reset = 1'b1;
    #1;
    chk("rstg_pause", 32'(pause_req), 32'd0);
    chk("rstg_busy", 32'(hs_busy), 32'd0);
    chk("rstg_addr", 32'(ram_addr), 32'h3AB);
    tick();
    reset = 1'b0; hs_read_intent = 1'b0; cpu_paused = 1'b0;
    tick();
    chk("rstg_after", 32'(pause_req), 32'd0);
`ifdef HSARB_VBLANK_SYNC_EN
    vblank = 1'b0; hs_read_intent = 1'b1;
    pr = 0;
    repeat (50) begin
      tick();
      pr += int'(pause_req);
    end
    chk("vb_hold_off", 32'(pr), 32'd0);
    vblank = 1'b1;
    tick();
    chk("vb_pause_req", 32'(pause_req), 32'd1);
    hs_read_intent = 1'b0;
    tick();
`else
    pr = 0;
    vblank = 1'b0; hs_read_intent = 1'b1;
    tick();
    pr += int'(pause_req);
    chk("vb_ignored", 32'(pr), 32'd1);
    hs_read_intent = 1'b0;
    tick();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hiscore_ram_arbiter.md
Name: hiscore_ram_arbiter

Overview:
- Shares the game work-RAM port between the running CPU and the hiscore engine.
- On a hiscore read/write intent: requests a CPU pause, waits for the pause to take effect, settles, then hands the RAM port to the hiscore engine.
- Returns the port to the CPU cleanly when the engine finishes.
- Sits between the hiscore engine, the pause module and the game core's hiscore RAM port, all in the clk_sys domain.

Parameters:
- AW, 11, RAM address width.
- RD_LAT, 1, RAM read latency in cycles (1..3).
- SETTLE, 4, cycles from cpu_paused high to grant.
- HOLD, 2, cycles after release before pause_req drops.
- TIMEOUT, 65535, max cycles waiting for cpu_paused before abort.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hs_read_intent  in  1  engine wants read access
- hs_write_intent  in  1  engine wants write access
- hs_address  in  AW  engine address
- hs_data_in  in  8  engine write data
- hs_write_enable  in  1  engine write strobe, one cycle per byte
- hs_data_out  out  8  read data to engine
- hs_rdata_valid  out  1  hs_data_out valid for current hs_address
- hs_busy  out  1  engine owns RAM port
- hs_abort  out  1  one-cycle pulse: request abandoned
- pause_req  out  1  to pause module (pause_request)
- cpu_paused  in  1  from pause module (paused)
- cpu_addr  in  AW  core address
- cpu_din  in  8  core write data
- cpu_we  in  1  core write strobe
- cpu_dout  out  8  read data to core
- ram_addr  out  AW  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  8  RAM read data
- vblank  in  1  used only when VBLANK_SYNC_EN is defined

Behaviour:
- Reset values: state IDLE; pause_req=0, hs_busy=0, hs_abort=0, hs_rdata_valid=0, hs_data_out=0; port muxed to CPU. Reset mid-grant returns the port to the CPU immediately and drops pause_req.
- intent = hs_read_intent | hs_write_intent.
- Mux:
  - hs_busy=0: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we.
  - hs_busy=1: ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write_enable, cpu_we ignored.
  - cpu_dout=ram_dout always (combinational).
  - hs_write_enable while hs_busy=0 is dropped, never reaches RAM.
- States:
  - IDLE: intent=1 -> REQ; pause_req=1 from the next cycle.
  - REQ: counter counts up.
    - cpu_paused=1 -> SETTLE.
    - Counter reaches TIMEOUT -> hs_abort pulse, pause_req=0, -> IDLE.
    - intent drops -> IDLE, pause_req=0, no abort.
  - SETTLE: count SETTLE cycles -> GRANT; hs_busy=1 on the first GRANT cycle.
    - cpu_paused drops -> REQ, counter cleared.
  - GRANT: engine owns the port.
    - intent=0 -> RELEASE; hs_busy=0 on the first RELEASE cycle.
    - cpu_paused drops -> hs_abort pulse, hs_busy=0 and ram_we forced 0 in the same cycle, -> IDLE.
  - RELEASE: count HOLD cycles, then pause_req=0 -> IDLE.
    - intent reasserts before the count expires -> GRANT directly, no SETTLE.
- Read path:
  - hs_data_out is ram_dout registered.
  - hs_rdata_valid=1 once hs_address has been stable for RD_LAT+1 cycles in GRANT with hs_read_intent=1.
  - Any address change, or leaving GRANT, clears hs_rdata_valid next cycle.
- Write path: zero added latency; hs_write_enable in GRANT appears on ram_we the same cycle.
- Simultaneous read and write intent: treated as one intent; a write strobe in a cycle clears hs_rdata_valid.
- Counters saturate; TIMEOUT counter width is $clog2(TIMEOUT+1).

Optional Feature:
- Macro: HSARB_VBLANK_SYNC_EN.
- Defined: IDLE->REQ transition additionally requires vblank=1. While intent is pending and vblank=0, the block stays in IDLE with pause_req=0, and the TIMEOUT counter does not run.
- Undefined: vblank port present but ignored; behaviour as above.

Test Plan:
- Read handshake: hs_read_intent=1, cpu_paused rises 5 cycles after pause_req, SETTLE=4, RD_LAT=1, RAM[0x123]=0xA5, hs_address=0x123 -> hs_busy high 4 cycles after cpu_paused; hs_rdata_valid 2 cycles later with hs_data_out=0xA5; cpu_we pulses during grant never reach ram_we.
- Write then release: hs_write_intent with writes 0x11,0x22 to 0x000,0x001, then intent=0 -> RAM holds both bytes; hs_busy falls next cycle; pause_req falls HOLD=2 cycles later; port back to CPU.
- Timeout: intent=1, cpu_paused held 0, TIMEOUT=100 -> hs_abort single pulse at cycle 100 after REQ entry; pause_req=0; hs_busy never asserted.
- Re-grant in RELEASE: intent drops, reasserts 1 cycle later -> GRANT without SETTLE; pause_req stays 1 throughout.
- Reset mid-GRANT: assert reset asynchronously -> pause_req=0, hs_busy=0, ram_addr follows cpu_addr in the same cycle.
- HSARB_VBLANK_SYNC_EN defined: intent raised with vblank=0 for 50 cycles -> pause_req stays 0; vblank rises -> pause_req=1 next cycle.
